// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS datapath.
// Provides datapath/register-file geometry, the ALU select encodings, and
// the immediate sign-extend helper used by the operand stage.
package mips_pkg;

  localparam int WIDTH  = 16;  // datapath width
  localparam int NREGS  = 8;   // register count
  localparam int REG_AW = 3;   // register address width
  localparam int IMM_W  = 7;   // immediate field width

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_PASS1 = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;

  // Replicate the immediate's top bit up to the datapath width.
  function automatic logic [WIDTH-1:0] sign_extend(input logic [IMM_W-1:0] imm);
    return {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// reg_file: NREGS x WIDTH register file.
// Ports:
//   clock            rising-edge clock
//   reset            synchronous active-low clear of every register
//   we/waddr/wdata   synchronous write port (writes to R0 are dropped)
//   raddr_a/rdata_a  combinational read port A
//   raddr_b/rdata_b  combinational read port B
// R0 has no storage and always reads as zero.
module reg_file
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [NREGS-1:0][WIDTH-1:0] words;

  assign words[0] = '0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [WIDTH-1:0] word_q;

      always_ff @(posedge clock) begin
        if (!reset) begin
          word_q <= '0;
        end else if (we && (waddr == REG_AW'(gi))) begin
          word_q <= wdata;
        end
      end

      assign words[gi] = word_q;
    end
  endgenerate

  assign rdata_a = words[raddr_a];
  assign rdata_b = words[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode-to-execute stage of the 16-bit MIPS datapath.
// Holds the register file, resolves both source operands (R0 / EX forward /
// writeback bypass / register file), selects the immediate for operand B,
// and registers the result into the EX slot with stall and flush control.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   in_valid, rs, rt, imm,
//   use_imm, alu_sel_in, rd_in   decoded instruction
//   stall, flush                 hold EX slot / load a bubble (flush wins)
//   ex_fwd_en/addr/data          result currently in EX
//   wb_en/addr/data              register file write port (also bypassed)
//   ex_valid, ex_a, ex_b,
//   ex_alu_sel, ex_rd            registered EX slot
module alu_operand_stage
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic [2:0]        alu_sel_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_fwd_addr,
  input  logic [WIDTH-1:0]  ex_fwd_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_a,
  output logic [WIDTH-1:0]  ex_b,
  output logic [2:0]        ex_alu_sel,
  output logic [REG_AW-1:0] ex_rd
);

  logic [WIDTH-1:0] rf_a, rf_b;
  logic [WIDTH-1:0] op_a, op_rt, op_b;

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        sel_q, sel_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  reg_file u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // The younger EX result beats the older writeback value; R0 is checked
  // first so a stray forward or write to R0 can never leak through.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [REG_AW-1:0] addr,
    input logic [WIDTH-1:0]  rf_val,
    input logic              fwd_en,
    input logic [REG_AW-1:0] fwd_addr,
    input logic [WIDTH-1:0]  fwd_data,
    input logic              wen,
    input logic [REG_AW-1:0] waddr,
    input logic [WIDTH-1:0]  wdata
  );
    if (addr == '0)                         return '0;
    else if (fwd_en && (fwd_addr == addr))  return fwd_data;
    else if (wen && (waddr == addr))        return wdata;
    else                                    return rf_val;
  endfunction

  always_comb begin
    op_a  = resolve(rs, rf_a, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                    wb_en, wb_addr, wb_data);
    op_rt = resolve(rt, rf_b, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                    wb_en, wb_addr, wb_data);
    op_b  = use_imm ? sign_extend(imm) : op_rt;
  end

  // Next EX slot contents; reset is applied in the register process.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
      rd_d    = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      if (in_valid) begin
        a_d   = op_a;
        b_d   = op_b;
        sel_d = alu_sel_in;
        rd_d  = rd_in;
      end else begin
        a_d   = '0;
        b_d   = '0;
        sel_d = '0;
        rd_d  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_a       = a_q;
  assign ex_b       = b_q;
  assign ex_alu_sel = sel_q;
  assign ex_rd      = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: table-driven single-cycle vectors plus
// hand-written reset and stall/flush sequences.
module tb_alu_operand_stage;
  import mips_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [2:0]        rs, rt, alu_sel_in, rd_in;
  logic [6:0]        imm;
  logic              use_imm, stall, flush;
  logic              ex_fwd_en;
  logic [2:0]        ex_fwd_addr;
  logic [15:0]       ex_fwd_data;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [15:0]       wb_data;
  logic              ex_valid;
  logic [15:0]       ex_a, ex_b;
  logic [2:0]        ex_alu_sel, ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_operand_stage dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .use_imm     (use_imm),
    .alu_sel_in  (alu_sel_in),
    .rd_in       (rd_in),
    .stall       (stall),
    .flush       (flush),
    .ex_fwd_en   (ex_fwd_en),
    .ex_fwd_addr (ex_fwd_addr),
    .ex_fwd_data (ex_fwd_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_alu_sel  (ex_alu_sel),
    .ex_rd       (ex_rd)
  );

  typedef struct {
    string       name;
    logic        in_valid;
    logic [2:0]  rs, rt;
    logic [6:0]  imm;
    logic        use_imm;
    logic [2:0]  sel, rd;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        fwd_en;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        e_valid;
    logic [15:0] e_a, e_b;
    logic [2:0]  e_sel, e_rd;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(
    input string n, input logic v, input logic [2:0] s, input logic [2:0] t,
    input logic [6:0] im, input logic ui, input logic [2:0] sl, input logic [2:0] d,
    input logic we, input logic [2:0] wa, input logic [15:0] wd,
    input logic fe, input logic [2:0] fa, input logic [15:0] fd,
    input logic ev, input logic [15:0] ea, input logic [15:0] eb,
    input logic [2:0] es, input logic [2:0] er);
    vec_t r;
    r.name = n; r.in_valid = v; r.rs = s; r.rt = t; r.imm = im; r.use_imm = ui;
    r.sel = sl; r.rd = d; r.wb_en = we; r.wb_addr = wa; r.wb_data = wd;
    r.fwd_en = fe; r.fwd_addr = fa; r.fwd_data = fd;
    r.e_valid = ev; r.e_a = ea; r.e_b = eb; r.e_sel = es; r.e_rd = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic check_ex(input string name, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] s, input logic [2:0] d);
    check({name, ".valid"}, {15'd0, ex_valid}, {15'd0, v});
    check({name, ".a"}, ex_a, a);
    check({name, ".b"}, ex_b, b);
    check({name, ".sel"}, {13'd0, ex_alu_sel}, {13'd0, s});
    check({name, ".rd"}, {13'd0, ex_rd}, {13'd0, d});
    $display("%s: valid=%0b a=%04h b=%04h sel=%0d rd=%0d", name, ex_valid, ex_a, ex_b,
             ex_alu_sel, ex_rd);
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs = 0; rt = 0; imm = 0; use_imm = 0; alu_sel_in = 0; rd_in = 0;
    stall = 0; flush = 0; ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] s, input logic [2:0] t, input logic [6:0] im,
                       input logic ui, input logic [2:0] sl, input logic [2:0] d);
    in_valid = 1; rs = s; rt = t; imm = im; use_imm = ui; alu_sel_in = sl; rd_in = d;
  endtask

  initial begin
    // Table: register file starts cleared; each row is one cycle and the
    // file state carries from row to row.
    vecs[0]  = mk("bypass_r2",   1, 2, 0, 7'h00, 0, ALU_ADD,   1, 1, 2, 16'h0004, 0, 0, 16'h0000,
                  1, 16'h0004, 16'h0000, ALU_ADD, 1);
    vecs[1]  = mk("bubble_wr_r5", 0, 2, 2, 7'h00, 0, ALU_SUB,  3, 1, 5, 16'h0007, 0, 0, 16'h0000,
                  0, 16'h0000, 16'h0000, 3'd0, 3'd0);
    vecs[2]  = mk("fwd_over_wb", 1, 5, 2, 7'h00, 0, ALU_SUB,   3, 1, 5, 16'h0009, 1, 5, 16'h000B,
                  1, 16'h000B, 16'h0004, ALU_SUB, 3);
    vecs[3]  = mk("wb_over_file", 1, 5, 0, 7'h00, 0, ALU_OR,   2, 1, 5, 16'h0011, 1, 4, 16'h0EEE,
                  1, 16'h0011, 16'h0000, ALU_OR, 2);
    vecs[4]  = mk("file_r5",     1, 5, 5, 7'h00, 0, ALU_AND,   5, 0, 0, 16'h0000, 0, 0, 16'h0000,
                  1, 16'h0011, 16'h0011, ALU_AND, 5);
    vecs[5]  = mk("imm_neg",     1, 2, 5, 7'b1000000, 1, ALU_PASS1, 6, 0, 0, 16'h0000, 0, 0, 16'h0000,
                  1, 16'h0004, 16'hFFC0, ALU_PASS1, 6);
    vecs[6]  = mk("imm_pos",     1, 0, 5, 7'b0111111, 1, ALU_OR, 7, 0, 0, 16'h0000, 0, 0, 16'h0000,
                  1, 16'h0000, 16'h003F, ALU_OR, 7);
    vecs[7]  = mk("r0_same_cyc", 1, 0, 0, 7'h00, 0, ALU_AND,   2, 1, 0, 16'hFFFF, 1, 0, 16'h5555,
                  1, 16'h0000, 16'h0000, ALU_AND, 2);
    vecs[8]  = mk("r0_after_wr", 1, 0, 0, 7'h00, 0, ALU_ADD,   4, 0, 0, 16'h0000, 0, 0, 16'h0000,
                  1, 16'h0000, 16'h0000, ALU_ADD, 4);
    vecs[9]  = mk("fwd_rt",      1, 2, 5, 7'h00, 0, ALU_SUB,   4, 1, 3, 16'h00AA, 1, 5, 16'h0CCC,
                  1, 16'h0004, 16'h0CCC, ALU_SUB, 4);
    vecs[10] = mk("file_r3",     1, 3, 3, 7'h00, 0, ALU_OR,    1, 0, 0, 16'h0000, 0, 0, 16'h0000,
                  1, 16'h00AA, 16'h00AA, ALU_OR, 1);

    idle_inputs();

    // Reset sequence: put something non-zero in EX first so the clear is visible.
    reset = 0;
    tick();
    reset = 1;
    issue(0, 0, 7'h05, 1, ALU_SUB, 6);
    tick();
    check_ex("pre_reset_load", 1, 16'h0000, 16'h0005, ALU_SUB, 6);

    reset = 0; wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
    tick();
    check_ex("reset_cyc1", 0, 0, 0, 0, 0);
    tick();
    check_ex("reset_cyc2", 0, 0, 0, 0, 0);
    idle_inputs();
    reset = 1;
    tick();
    check_ex("after_reset_idle", 0, 0, 0, 0, 0);
    issue(3, 3, 7'h00, 0, ALU_ADD, 1);
    tick();
    check_ex("read_r3_post_reset", 1, 16'h0000, 16'h0000, ALU_ADD, 1);
    idle_inputs();
    tick();

    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].in_valid; rs = vecs[i].rs; rt = vecs[i].rt;
      imm = vecs[i].imm; use_imm = vecs[i].use_imm; alu_sel_in = vecs[i].sel;
      rd_in = vecs[i].rd; wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr;
      wb_data = vecs[i].wb_data; ex_fwd_en = vecs[i].fwd_en;
      ex_fwd_addr = vecs[i].fwd_addr; ex_fwd_data = vecs[i].fwd_data;
      stall = 0; flush = 0;
      tick();
      check_ex(vecs[i].name, vecs[i].e_valid, vecs[i].e_a, vecs[i].e_b,
               vecs[i].e_sel, vecs[i].e_rd);
    end
    idle_inputs();

    // Stall/flush. File now: R2=4, R3=AA, R5=11.
    issue(2, 5, 7'h00, 0, ALU_ADD, 1);
    tick();
    check_ex("load_A", 1, 16'h0004, 16'h0011, ALU_ADD, 1);

    // Present B (rs=3, imm=5) while stalled; R3 is rewritten during the stall.
    issue(3, 0, 7'h05, 1, ALU_OR, 7);
    stall = 1;
    wb_en = 1; wb_addr = 3; wb_data = 16'h0BBB;
    tick();
    check_ex("stall_1", 1, 16'h0004, 16'h0011, ALU_ADD, 1);
    wb_en = 0;
    tick();
    check_ex("stall_2", 1, 16'h0004, 16'h0011, ALU_ADD, 1);
    tick();
    check_ex("stall_3", 1, 16'h0004, 16'h0011, ALU_ADD, 1);
    flush = 1;
    tick();
    check_ex("stall_flush", 0, 0, 0, 0, 0);
    stall = 0; flush = 0;
    tick();
    check_ex("B_after_release", 1, 16'h0BBB, 16'h0005, ALU_OR, 7);

    // Flush alone on a valid input also produces a bubble.
    flush = 1;
    tick();
    check_ex("flush_only", 0, 0, 0, 0, 0);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
